// File: rtl/rv32_mem_pkg.sv
//============================================================================
// Module  : rv32_mem_pkg
// Purpose : Shared encodings for the RV32 data-memory access path: access
//           size codes, access-sequencer state enum, memory opcodes and a
//           misalignment helper.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

package rv32_mem_pkg;

    // Access-size encodings as carried by the M-stage controls
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Major opcodes of loads and stores
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_SECOND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Size code 3 is handled as a word.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
//============================================================================
// Module  : mem_lane_align
// Purpose : Combinational byte-lane steering for data-memory accesses.
//           Produces 8-bit byte enables and 64-bit write data spanning two
//           consecutive words, and extracts/extends load data from the
//           64-bit {hi,lo} read pair.
// Ports   : i_off        byte offset within the word (addr[1:0])
//           i_size       access size code
//           i_unsigned   zero-extend the load result
//           i_wdata      store data, right-aligned
//           i_rdata64    {hi,lo} read words
//           o_be8        byte enables, [3:0] beat 0, [7:4] beat 1
//           o_wd64       write data, [31:0] beat 0, [63:32] beat 1
//           o_load_data  aligned and extended load result
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rdata64,
    output logic [7:0]  o_be8,
    output logic [63:0] o_wd64,
    output logic [31:0] o_load_data
);

    logic [3:0]  w_mask;
    logic [31:0] w_rep;
    logic [31:0] w_shift;
    logic        w_sign;

    always_comb begin
        w_mask = 4'hF;
        w_rep  = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                w_mask = 4'h1;
                w_rep  = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_mask = 4'h3;
                w_rep  = {2{i_wdata[15:0]}};
            end
            default: begin
            end
        endcase

        o_be8  = {4'h0, w_mask} << i_off;
        o_wd64 = {32'h0, w_rep} << {i_off, 3'b000};

        // Only the low word of the shifted pair can hold the addressed bytes
        w_shift = 32'(i_rdata64 >> {i_off, 3'b000});

        case (i_size)
            SZ_BYTE: begin
                w_sign      = ~i_unsigned & w_shift[7];
                o_load_data = {{24{w_sign}}, w_shift[7:0]};
            end
            SZ_HALF: begin
                w_sign      = ~i_unsigned & w_shift[15];
                o_load_data = {{16{w_sign}}, w_shift[15:0]};
            end
            default: begin
                w_sign      = 1'b0;
                o_load_data = w_shift;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
//============================================================================
// Module  : dmem_access_ctrl
// Purpose : Sequences M-stage loads/stores onto a req/ack data-memory port,
//           stalls the pipeline until completion and returns aligned,
//           extended load data. Faults (misalignment, ack timeout) are
//           flagged in the DONE cycle that retires the instruction.
// Config  : MEM_MISALIGN_SPLIT_EN - when defined, misaligned accesses are
//           performed (split into two beats when crossing a word); when
//           undefined they fault without issuing a request.
// Ports   : clk, reset (sync, active-high)
//           m_valid, m_mem_r_w, m_access_size, m_load_unsigned, m_addr,
//           m_wdata                     - M-stage access request
//           stall                       - hold the pipeline
//           load_data, load_valid       - W-stage load result
//           misaligned, timeout         - one-cycle fault pulses
//           dmem_req/we/addr/be/wdata   - memory request (registered)
//           dmem_ack, dmem_rdata        - memory response
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module dmem_access_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic              m_mem_r_w,
    input  logic [1:0]        m_access_size,
    input  logic              m_load_unsigned,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misaligned,
    output logic              timeout,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] c_WAIT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;
    localparam bit c_TMO_EN = (MAX_WAIT > 0);

    state_t             r_state, w_state_nxt;

    // Latched copy of the access
    logic               r_rw,    w_rw_nxt;
    logic [1:0]         r_size,  w_size_nxt;
    logic               r_uns,   w_uns_nxt;
    logic [1:0]         r_off,   w_off_nxt;
    logic [31:0]        r_wdata, w_wdata_nxt;
    logic [31:0]        r_lo,    w_lo_nxt;
    logic [CNT_W-1:0]   r_wait,  w_wait_nxt;

    // Registered outputs
    logic               r_req,    w_req_nxt;
    logic               r_we,     w_we_nxt;
    logic [ADDR_W-1:0]  r_daddr,  w_daddr_nxt;
    logic [3:0]         r_be,     w_be_nxt;
    logic [31:0]        r_dwd,    w_dwd_nxt;
    logic [31:0]        r_ldata,  w_ldata_nxt;
    logic               r_lvalid, w_lvalid_nxt;
    logic               r_misal,  w_misal_nxt;
    logic               r_tmo,    w_tmo_nxt;

    logic               w_stall;

    // Lane math runs on the live M-stage inputs in IDLE (so the first beat
    // can be registered at the same edge that latches the access) and on
    // the latched copy afterwards.
    logic               w_idle;
    logic [1:0]         w_off;
    logic [1:0]         w_size;
    logic               w_uns;
    logic [31:0]        w_wdata;
    logic [31:0]        w_lo_in;
    logic [31:0]        w_hi_in;
    logic [7:0]         w_be8;
    logic [63:0]        w_wd64;
    logic [31:0]        w_ext;
    logic               w_fault;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_off   = w_idle ? m_addr[1:0]     : r_off;
    assign w_size  = w_idle ? m_access_size   : r_size;
    assign w_uns   = w_idle ? m_load_unsigned : r_uns;
    assign w_wdata = w_idle ? m_wdata         : r_wdata;

    // Read word arriving this cycle is folded in so the final load result
    // can be registered on the completing ack.
    assign w_lo_in = ((r_state == ST_ACCESS) && dmem_ack) ? dmem_rdata : r_lo;
    assign w_hi_in = ((r_state == ST_SECOND) && dmem_ack) ? dmem_rdata : 32'h0;

`ifdef MEM_MISALIGN_SPLIT_EN
    assign w_fault = 1'b0;
`else
    assign w_fault = is_misaligned(m_access_size, m_addr[1:0]);
`endif

    mem_lane_align u_lane (
        .i_off       (w_off),
        .i_size      (w_size),
        .i_unsigned  (w_uns),
        .i_wdata     (w_wdata),
        .i_rdata64   ({w_hi_in, w_lo_in}),
        .o_be8       (w_be8),
        .o_wd64      (w_wd64),
        .o_load_data (w_ext)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_rw_nxt     = r_rw;
        w_size_nxt   = r_size;
        w_uns_nxt    = r_uns;
        w_off_nxt    = r_off;
        w_wdata_nxt  = r_wdata;
        w_lo_nxt     = w_lo_in;
        w_wait_nxt   = r_wait;
        w_req_nxt    = r_req;
        w_we_nxt     = r_we;
        w_daddr_nxt  = r_daddr;
        w_be_nxt     = r_be;
        w_dwd_nxt    = r_dwd;
        w_ldata_nxt  = r_ldata;
        w_lvalid_nxt = 1'b0;
        w_misal_nxt  = 1'b0;
        w_tmo_nxt    = 1'b0;
        w_stall      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_stall = m_valid;
                if (m_valid) begin
                    w_rw_nxt    = m_mem_r_w;
                    w_size_nxt  = m_access_size;
                    w_uns_nxt   = m_load_unsigned;
                    w_off_nxt   = m_addr[1:0];
                    w_wdata_nxt = m_wdata;
                    if (w_fault) begin
                        w_state_nxt = ST_DONE;
                        w_misal_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = ~m_mem_r_w;
                        w_daddr_nxt = {m_addr[ADDR_W-1:2], 2'b00};
                        w_be_nxt    = w_be8[3:0];
                        w_dwd_nxt   = w_wd64[31:0];
                        w_wait_nxt  = '0;
                    end
                end
            end

            ST_ACCESS, ST_SECOND: begin
                w_stall = 1'b1;
                if (dmem_ack) begin
                    if ((r_state == ST_ACCESS) && (w_be8[7:4] != 4'h0)) begin
                        // Bytes spill into the next word: keep req high and
                        // move straight on to the second beat.
                        w_state_nxt = ST_SECOND;
                        w_daddr_nxt = r_daddr + ADDR_W'(4);
                        w_be_nxt    = w_be8[7:4];
                        w_dwd_nxt   = w_wd64[63:32];
                        w_wait_nxt  = '0;
                    end else begin
                        w_state_nxt  = ST_DONE;
                        w_req_nxt    = 1'b0;
                        w_we_nxt     = 1'b0;
                        w_be_nxt     = 4'h0;
                        w_lvalid_nxt = r_rw;
                        if (r_rw) begin
                            w_ldata_nxt = w_ext;
                        end
                    end
                end else if (c_TMO_EN && (r_wait == c_WAIT_LAST)) begin
                    w_state_nxt = ST_DONE;
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_be_nxt    = 4'h0;
                    w_tmo_nxt   = 1'b1;
                end else if (c_TMO_EN) begin
                    w_wait_nxt = r_wait + CNT_W'(1);
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rw     <= 1'b0;
            r_size   <= 2'b00;
            r_uns    <= 1'b0;
            r_off    <= 2'b00;
            r_wdata  <= 32'h0;
            r_lo     <= 32'h0;
            r_wait   <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_daddr  <= '0;
            r_be     <= 4'h0;
            r_dwd    <= 32'h0;
            r_ldata  <= 32'h0;
            r_lvalid <= 1'b0;
            r_misal  <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rw     <= w_rw_nxt;
            r_size   <= w_size_nxt;
            r_uns    <= w_uns_nxt;
            r_off    <= w_off_nxt;
            r_wdata  <= w_wdata_nxt;
            r_lo     <= w_lo_nxt;
            r_wait   <= w_wait_nxt;
            r_req    <= w_req_nxt;
            r_we     <= w_we_nxt;
            r_daddr  <= w_daddr_nxt;
            r_be     <= w_be_nxt;
            r_dwd    <= w_dwd_nxt;
            r_ldata  <= w_ldata_nxt;
            r_lvalid <= w_lvalid_nxt;
            r_misal  <= w_misal_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

    assign stall      = reset ? 1'b0 : w_stall;
    assign load_data  = r_ldata;
    assign load_valid = r_lvalid;
    assign misaligned = r_misal;
    assign timeout    = r_tmo;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_daddr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_dwd;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
//============================================================================
// Module  : tb_dmem_access_ctrl
// Purpose : Scoreboard bench for dmem_access_ctrl. Directed accesses push
//           expected memory beats and retirement results into queues; a
//           monitor pops and compares whenever the DUT completes a beat or
//           retires an access. A responder models memory wait states.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_mem_r_w, m_load_unsigned;
    logic [1:0]  m_access_size;
    logic [31:0] m_addr, m_wdata;
    logic        stall, load_valid, misaligned, timeout;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int total = 0;
    int bad   = 0;

    dmem_access_ctrl #(.ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_mem_r_w(m_mem_r_w), .m_access_size(m_access_size),
        .m_load_unsigned(m_load_unsigned), .m_addr(m_addr), .m_wdata(m_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misaligned(misaligned), .timeout(timeout),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } beat_t;

    typedef struct {
        logic        lv;
        logic [31:0] ld;
        logic        mis;
        logic        tmo;
        int          sc;
        int          rc;
    } ret_t;

    beat_t beat_q[$];
    ret_t  ret_q[$];
    int    retire_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic we, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd);
        beat_t b;
        b.we = we; b.addr = a; b.be = be; b.wd = wd;
        beat_q.push_back(b);
    endtask

    task automatic push_ret(input logic lv, input logic [31:0] ld, input logic mis,
                            input logic tmo, input int sc, input int rc);
        ret_t r;
        r.lv = lv; r.ld = ld; r.mis = mis; r.tmo = tmo; r.sc = sc; r.rc = rc;
        ret_q.push_back(r);
    endtask

    // ---------------- memory responder ----------------
    bit          rsp_en = 1'b1;
    int          rsp_wait[2];
    logic [31:0] rsp_data[2];
    int          bidx = 0;
    int          wcnt = 0;

    initial begin
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rsp_en) begin
                dmem_ack = 1'b0;
                if (dmem_req && !reset && bidx < 2) begin
                    if (wcnt == rsp_wait[bidx]) begin
                        dmem_ack   = 1'b1;
                        dmem_rdata = rsp_data[bidx];
                        wcnt = 0;
                        bidx++;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit prev_stall = 1'b0;
        int scnt = 0;
        int rcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0; scnt = 0; rcnt = 0;
            end else begin
                if (dmem_req) rcnt++;
                if (dmem_req && dmem_ack) begin
                    if (beat_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL beat_unexpected actual addr=%h required none", dmem_addr);
                    end else begin
                        beat_t e;
                        e = beat_q.pop_front();
                        chk("beat_we",   32'(dmem_we), 32'(e.we));
                        chk("beat_addr", dmem_addr, e.addr);
                        chk("beat_be",   32'(dmem_be), 32'(e.be));
                        if (e.we) chk("beat_wdata", dmem_wdata, e.wd);
                    end
                end
                if (stall) begin
                    scnt++;
                end else if (prev_stall) begin
                    if (ret_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL retire_unexpected actual lv=%0b required none", load_valid);
                    end else begin
                        ret_t r;
                        r = ret_q.pop_front();
                        chk("ret_load_valid", 32'(load_valid), 32'(r.lv));
                        chk("ret_misaligned", 32'(misaligned), 32'(r.mis));
                        chk("ret_timeout",    32'(timeout),    32'(r.tmo));
                        chk("ret_stall_cyc",  32'(scnt),       32'(r.sc));
                        chk("ret_req_cyc",    32'(rcnt),       32'(r.rc));
                        if (r.lv) chk("ret_load_data", load_data, r.ld);
                    end
                    retire_cnt++;
                    scnt = 0; rcnt = 0;
                end else begin
                    chk("idle_pulses", 32'({load_valid, misaligned, timeout}), 32'h0);
                end
                prev_stall = stall;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic rw, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int w0, input logic [31:0] d0,
                         input int w1, input logic [31:0] d1);
        int start;
        rsp_wait[0] = w0; rsp_data[0] = d0;
        rsp_wait[1] = w1; rsp_data[1] = d1;
        bidx = 0; wcnt = 0;
        start = retire_cnt;
        m_valid = 1'b1; m_mem_r_w = rw; m_access_size = sz;
        m_load_unsigned = uns; m_addr = a; m_wdata = wd;
        for (int i = 0; i < 100 && retire_cnt == start; i++) @(posedge clk);
        if (retire_cnt == start) begin
            total++; bad++;
            $display("FAIL retire_wait actual=no_retire required=retire addr=%h", a);
        end
        #1;
        m_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m_valid = 1'b1; m_mem_r_w = 1'b1; m_access_size = 2'd2;
        m_load_unsigned = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall",      32'(stall),      32'h0);
        chk("rst_req",        32'(dmem_req),   32'h0);
        chk("rst_we",         32'(dmem_we),    32'h0);
        chk("rst_addr",       dmem_addr,       32'h0);
        chk("rst_be",         32'(dmem_be),    32'h0);
        chk("rst_wdata",      dmem_wdata,      32'h0);
        chk("rst_load_data",  load_data,       32'h0);
        chk("rst_load_valid", 32'(load_valid), 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);
        chk("rst_timeout",    32'(timeout),    32'h0);
        m_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Aligned word load
        push_beat(1'b0, 32'h100, 4'hF, 32'h0);
        push_ret(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2, 1);
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0);

        // LB / LBU at lane 3
        push_beat(1'b0, 32'h100, 4'h8, 32'h0);
        push_ret(1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 2, 1);
        issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80112233, 0, 32'h0);
        push_beat(1'b0, 32'h100, 4'h8, 32'h0);
        push_ret(1'b1, 32'h00000080, 1'b0, 1'b0, 2, 1);
        issue(1'b1, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80112233, 0, 32'h0);

        // SH with three wait states
        push_beat(1'b1, 32'h200, 4'hC, 32'hABCD0000);
        push_ret(1'b0, 32'h0, 1'b0, 1'b0, 5, 4);
        issue(1'b0, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'h0, 0, 32'h0);

        // Misaligned word load at 0x301
`ifdef MEM_MISALIGN_SPLIT_EN
        push_beat(1'b0, 32'h300, 4'hE, 32'h0);
        push_beat(1'b0, 32'h304, 4'h1, 32'h0);
        push_ret(1'b1, 32'h55443322, 1'b0, 1'b0, 3, 2);
`else
        push_ret(1'b0, 32'h0, 1'b1, 1'b0, 1, 0);
`endif
        issue(1'b1, 2'd2, 1'b0, 32'h301, 32'h0, 0, 32'h44332211, 0, 32'h88776655);

        // No ack: times out after four wait cycles
        push_ret(1'b0, 32'h0, 1'b0, 1'b1, 5, 4);
        issue(1'b1, 2'd2, 1'b0, 32'h400, 32'h0, 1000, 32'h0, 0, 32'h0);

        // SB at lane 1
        push_beat(1'b1, 32'h0, 4'h2, 32'hA5A5A500);
        push_ret(1'b0, 32'h0, 1'b0, 1'b0, 2, 1);
        issue(1'b0, 2'd0, 1'b0, 32'h001, 32'h000000A5, 0, 32'h0, 0, 32'h0);

        // LH signed, one wait state
        push_beat(1'b0, 32'h4, 4'hC, 32'h0);
        push_ret(1'b1, 32'hFFFF8001, 1'b0, 1'b0, 3, 2);
        issue(1'b1, 2'd1, 1'b0, 32'h006, 32'h0, 1, 32'h80010000, 0, 32'h0);

        // LHU
        push_beat(1'b0, 32'h0, 4'hC, 32'h0);
        push_ret(1'b1, 32'h00009ABC, 1'b0, 1'b0, 2, 1);
        issue(1'b1, 2'd1, 1'b1, 32'h002, 32'h0, 0, 32'h9ABC1234, 0, 32'h0);

        // SW aligned
        push_beat(1'b1, 32'h10, 4'hF, 32'h12345678);
        push_ret(1'b0, 32'h0, 1'b0, 1'b0, 2, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h010, 32'h12345678, 0, 32'h0, 0, 32'h0);

        // SH at odd offset inside one word
`ifdef MEM_MISALIGN_SPLIT_EN
        push_beat(1'b1, 32'h4, 4'h6, 32'hCD11CD00);
        push_ret(1'b0, 32'h0, 1'b0, 1'b0, 2, 1);
`else
        push_ret(1'b0, 32'h0, 1'b1, 1'b0, 1, 0);
`endif
        issue(1'b0, 2'd1, 1'b0, 32'h005, 32'h000011CD, 0, 32'h0, 0, 32'h0);

        // Reset during ACCESS, ack arrives one cycle later
        rsp_en = 1'b0;
        dmem_ack = 1'b0;
        m_valid = 1'b1; m_mem_r_w = 1'b1; m_access_size = 2'd2;
        m_load_unsigned = 1'b0; m_addr = 32'h500;
        @(posedge clk); #1;
        m_valid = 1'b0;
        chk("mid_rst_req_before", 32'(dmem_req), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_stall_in_reset", 32'(stall), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        chk("mid_rst_req_after",  32'(dmem_req),   32'h0);
        chk("mid_rst_stall",      32'(stall),      32'h0);
        chk("mid_rst_load_valid", 32'(load_valid), 32'h0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("mid_rst_load_valid2", 32'(load_valid), 32'h0);
        chk("mid_rst_req2",        32'(dmem_req),   32'h0);
        rsp_en = 1'b1;
        repeat (2) @(posedge clk);

        chk("beat_q_left", 32'(beat_q.size()), 32'h0);
        chk("ret_q_left",  32'(ret_q.size()),  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
